// File: rtl/seq_pkg.sv
// Shared sequencer definitions: state encodings and the per-state LED seed pattern.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LEFT  = 2'b01,
    ST_RIGHT = 2'b10,
    ST_BLINK = 2'b11
  } seq_state_e;

  localparam int MAX_LED_W = 32;

  // Result is MAX_LED_W wide; callers truncate to their own LED width w.
  function automatic logic [MAX_LED_W-1:0] seed_pat(input logic [1:0] st, input int w);
    logic [MAX_LED_W-1:0] one;
    logic [MAX_LED_W-1:0] ones;
    one  = {{(MAX_LED_W-1){1'b0}}, 1'b1};
    ones = '1;
    case (st)
      ST_LEFT:  seed_pat = one;
      ST_RIGHT: seed_pat = one << (w - 1);
      ST_BLINK: seed_pat = ones >> (MAX_LED_W - w);
      default:  seed_pat = '0;
    endcase
  endfunction

endpackage

// File: rtl/moore_led_pattern_if.sv
// Sequencer-state / tick in, LED drive / step pulse out.
interface moore_led_pattern_if #(
  parameter int LED_W = 4
);
  logic             tick_mf;
  logic [1:0]       state;
  logic [LED_W-1:0] leds;
  logic             step;

  modport master (output tick_mf, state, input  leds, step);
  modport slave  (input  tick_mf, state, output leds, step);
endinterface

// File: rtl/led_dimmer.sv
// Free-running 16-cycle PWM gate applied to the LED pattern (LED_DIM_EN builds only).
module led_dimmer #(
  parameter int LED_W     = 4,
  parameter int DIM_LEVEL = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LED_W-1:0] pattern,
  output logic [LED_W-1:0] pwm
);
  logic [3:0] pwm_cnt;
  logic       on;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + 4'd1;
  end

  // DIM_LEVEL >= 16 keeps the gate permanently open, 0 keeps it shut.
  assign on  = int'(pwm_cnt) < DIM_LEVEL;
  assign pwm = pattern & {LED_W{on}};
endmodule

// File: rtl/moore_led_pattern.sv
// Moore sequencer output stage: per-state animated LED pattern stepped on 1 kHz ticks.
// Optional PWM dimming of the LEDs is built when LED_DIM_EN is defined.
module moore_led_pattern
  import seq_pkg::*;
#(
  parameter int LED_W     = 4,
  parameter int PER_LEFT  = 500,
  parameter int PER_RIGHT = 250,
  parameter int PER_BLINK = 125,
  parameter int DIM_LEVEL = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  moore_led_pattern_if.slave   bus
);
  localparam int PER_LR  = (PER_LEFT > PER_RIGHT) ? PER_LEFT : PER_RIGHT;
  localparam int PER_MAX = (PER_LR > PER_BLINK) ? PER_LR : PER_BLINK;
  localparam int CNT_W   = $clog2(PER_MAX + 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] ms_cnt, cnt_d, per_m1;
  logic [LED_W-1:0] pattern, pat_d, pat_adv;
  logic             step_q, step_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ms_cnt  <= '0;
      pattern <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ms_cnt  <= cnt_d;
      pattern <= pat_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    per_m1  = '0;
    pat_adv = pattern;
    case (state_q)
      ST_LEFT:  begin per_m1 = CNT_W'(PER_LEFT - 1);  pat_adv = {pattern[LED_W-2:0], pattern[LED_W-1]}; end
      ST_RIGHT: begin per_m1 = CNT_W'(PER_RIGHT - 1); pat_adv = {pattern[0], pattern[LED_W-1:1]};       end
      ST_BLINK: begin per_m1 = CNT_W'(PER_BLINK - 1); pat_adv = ~pattern;                               end
      default:  ;
    endcase
  end

  // A state change wins over a coincident tick, which is simply lost.
  always_comb begin
    state_d = state_q;
    cnt_d   = ms_cnt;
    pat_d   = pattern;
    step_d  = 1'b0;
    if (bus.state != state_q) begin
      state_d = bus.state;
      cnt_d   = '0;
      pat_d   = LED_W'(seed_pat(bus.state, LED_W));
    end else if (state_q == ST_IDLE) begin
      cnt_d = '0;
      pat_d = '0;
    end else if (bus.tick_mf) begin
      if (ms_cnt == per_m1) begin
        cnt_d  = '0;
        step_d = 1'b1;
        pat_d  = pat_adv;
      end else begin
        cnt_d = ms_cnt + 1'b1;
      end
    end
  end

`ifdef LED_DIM_EN
  logic [LED_W-1:0] leds_pwm;

  led_dimmer #(.LED_W(LED_W), .DIM_LEVEL(DIM_LEVEL)) u_dim (
    .clk     (clk),
    .rst_n   (rst_n),
    .pattern (pattern),
    .pwm     (leds_pwm)
  );

  always_comb begin
    bus.leds = leds_pwm;
    bus.step = step_q;
  end
`else
  logic unused_dim;
  assign unused_dim = ^DIM_LEVEL;

  always_comb begin
    bus.leds = pattern;
    bus.step = step_q;
  end
`endif

endmodule

// File: tb/tb_moore_led_pattern.sv
// Scoreboard bench for moore_led_pattern: tick every 10 clk, PER 4/2/3, LED_W=4.
module tb_moore_led_pattern;
  localparam int LED_W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  moore_led_pattern_if #(.LED_W(LED_W)) bus();

  moore_led_pattern #(
    .LED_W(LED_W), .PER_LEFT(4), .PER_RIGHT(2), .PER_BLINK(3), .DIM_LEVEL(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic       step;
    logic [3:0] leds;
  } obs_t;

  obs_t       sb[$];
  logic [3:0] exp_pat;
  int         exp_cnt;
  int         n_chk  = 0;
  int         n_fail = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] seed_of(input logic [1:0] s);
    case (s)
      2'b00:   return 4'b0000;
      2'b01:   return 4'b0001;
      2'b10:   return 4'b1000;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [3:0] adv(input logic [1:0] s, input logic [3:0] p);
    case (s)
      2'b01:   return {p[2:0], p[3]};
      2'b10:   return {p[0], p[3:1]};
      2'b11:   return ~p;
      default: return p;
    endcase
  endfunction

  task automatic set_state(input logic [1:0] s);
    bus.state = s;
    cyc();
    exp_pat = seed_of(s);
    exp_cnt = 0;
    n_chk++;
    if (bus.leds !== exp_pat || bus.step !== 1'b0) begin
      n_fail++;
      $display("FAIL seed_%b: leds=%b step=%b, expected leds=%b step=0", s, bus.leds, bus.step, exp_pat);
    end
  endtask

  // Between ticks the outputs must hold and step must stay low.
  task automatic idle_cycles(input int n, input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (bus.step !== 1'b0 || bus.leds !== exp_pat) bad++;
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s_hold: %0d cycles off (leds=%b step=%b), expected leds=%b step=0",
               name, bad, bus.leds, bus.step, exp_pat);
    end
  endtask

  task automatic run_ticks(input int n, input int per, input int exp_steps, input string name);
    obs_t e, got;
    int   steps;
    steps = 0;
    for (int k = 1; k <= n; k++) begin
      idle_cycles(9, name);
      e.step = 1'b0;
      if (bus.state != 2'b00) begin
        exp_cnt++;
        if (exp_cnt == per) begin
          exp_cnt = 0;
          exp_pat = adv(bus.state, exp_pat);
          e.step  = 1'b1;
        end
      end
      e.leds = exp_pat;
      sb.push_back(e);
      bus.tick_mf = 1'b1;
      cyc();
      bus.tick_mf = 1'b0;
      got = {bus.step, bus.leds};
      e   = sb.pop_front();
      if (got.step === 1'b1) steps++;
      n_chk++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s_tick%0d: step=%b leds=%b, expected step=%b leds=%b",
                 name, k, got.step, got.leds, e.step, e.leds);
      end
    end
    n_chk++;
    if (steps != exp_steps) begin
      n_fail++;
      $display("FAIL %s_step_count: %0d, expected %0d", name, steps, exp_steps);
    end
    idle_cycles(1, name);
  endtask

  task automatic test_reset();
    bus.state   = 2'b00;
    bus.tick_mf = 1'b0;
    rst_n       = 1'b0;
    cyc();
    cyc();
    n_chk++;
    if (bus.leds !== 4'b0000 || bus.step !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: leds=%b step=%b, expected leds=0000 step=0", bus.leds, bus.step);
    end
    rst_n   = 1'b1;
    exp_pat = 4'b0000;
    exp_cnt = 0;
    cyc();
    run_ticks(100, 1, 0, "idle");
  endtask

  task automatic test_left();
    set_state(2'b01);
    run_ticks(16, 4, 4, "left");
  endtask

  task automatic test_right();
    set_state(2'b10);
    run_ticks(8, 2, 4, "right");
  endtask

  task automatic test_blink();
    set_state(2'b11);
    run_ticks(6, 3, 2, "blink");
  endtask

  task automatic test_change_on_tick();
    obs_t e, got;
    set_state(2'b01);
    run_ticks(3, 4, 0, "pre_change");
    idle_cycles(9, "pre_change");
    bus.state   = 2'b11;
    bus.tick_mf = 1'b1;
    exp_pat     = 4'b1111;
    exp_cnt     = 0;
    sb.push_back('{step: 1'b0, leds: 4'b1111});
    cyc();
    bus.tick_mf = 1'b0;
    got = {bus.step, bus.leds};
    e   = sb.pop_front();
    n_chk++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL change_on_tick: step=%b leds=%b, expected step=%b leds=%b",
               got.step, got.leds, e.step, e.leds);
    end
    run_ticks(3, 3, 1, "post_change");
  endtask

  task automatic test_async_reset();
    set_state(2'b01);
    run_ticks(2, 4, 0, "pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus.leds !== 4'b0000 || bus.step !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: leds=%b step=%b, expected leds=0000 step=0", bus.leds, bus.step);
    end
    cyc();
    cyc();
    rst_n = 1'b1;
    set_state(2'b01);
    run_ticks(4, 4, 1, "post_rst");
  endtask

  initial begin
    test_reset();
    test_left();
    test_right();
    test_blink();
    test_change_on_tick();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
